// File: rtl/cache_def.sv
// Shared cache/memory types: request/response bundles and
// the main-memory controller state encoding.
package cache_def;

  localparam int LINE_OFF_BITS = 4;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_type;

endpackage

// File: rtl/mem_line_ctrl_if.sv
// Cache-to-memory line bus: request in, registered response
// and busy flag out.
interface mem_line_ctrl_if;
  import cache_def::*;

  mem_req_type  mem_req;
  mem_data_type mem_data;
  logic         busy;

  modport master (
    output mem_req,
    input  mem_data,
    input  busy
  );

  modport slave (
    input  mem_req,
    output mem_data,
    output busy
  );

endinterface

// File: rtl/mem_line_array.sv
// Single-port LINES x 128 synchronous line store; kept separate
// so a vendor RAM macro can drop in.
module mem_line_array #(
  parameter int LINES = 4096,
  localparam int IW = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] idx_i,
  input  logic [127:0]  wdata_i,
  output logic [127:0]  rdata_o
);

  logic [127:0] mem_q [LINES];
  logic [127:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_ctrl.sv
// Fixed-latency line memory behind the cache controller:
// IDLE accepts, BUSY counts down, RESP pulses ready.
module mem_line_ctrl
  import cache_def::*;
#(
  parameter int LINES     = 4096,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_line_ctrl_if.slave  bus
);

  localparam int IW   = $clog2(LINES);
  localparam int MAXL =
    (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] RL  = CW'(READ_LAT);
  localparam logic [CW-1:0] WL  = CW'(WRITE_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  mem_state_type  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q;
  cache_data_type wdat_q;
  logic           rw_q;
  cache_data_type rsp_q;
  logic           sel_q;
  cache_data_type rdata;
  logic           we, re, busy, ready, last, accept;
  logic           unused_addr;

  assign last   = (cnt_q == ONE);
  assign accept = (state_q == IDLE) && bus.mem_req.valid;
  assign unused_addr = ^bus.mem_req.addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      rw_q    <= 1'b0;
      rsp_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q  <= bus.mem_req.addr[LINE_OFF_BITS +: IW];
        wdat_q <= bus.mem_req.data;
        rw_q   <= bus.mem_req.rw;
      end
      // Writes echo from rsp_q; reads are served from the RAM register
      if (we) begin
        rsp_q <= wdat_q;
        sel_q <= 1'b0;
      end
      if (re) sel_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req.valid) begin
          state_d = BUSY;
          cnt_d   = bus.mem_req.rw ? WL : RL;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - ONE;
        if (last) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n keeps a reset on the last BUSY edge from committing
  always_comb begin
    we    = rst_n && (state_q == BUSY) && last && rw_q;
    re    = rst_n && (state_q == BUSY) && last && !rw_q;
    busy  = (state_q != IDLE);
    ready = (state_q == RESP);
  end

  mem_line_array #(
    .LINES (LINES)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .re_i    (re),
    .idx_i   (idx_q),
    .wdata_i (wdat_q),
    .rdata_o (rdata)
  );

  assign bus.mem_data.ready = ready;
  assign bus.mem_data.data  = sel_q ? rdata : rsp_q;
  assign bus.busy           = busy;

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Main-memory controller that sits directly downstream of the cache controller. It consumes `mem_req_type` requests (128-bit line read/write) and returns `mem_data_type` responses after a fixed, parameterised latency. Backing store is an on-chip line array. It serves as the cache's memory model in simulation and as a synthesizable scratch memory.

## Interface
Parameters:
- `LINES`, 4096: depth of the backing store in 128-bit lines; power of two, at least 2.
- `READ_LAT`, 4: read latency, in BUSY cycles; at least 1.
- `WRITE_LAT`, 2: write latency, in BUSY cycles; at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mem_req`  in  `mem_req_type`  fields: addr, data[127:0], rw (1 = write), valid.
- `mem_data`  out  `mem_data_type`  fields: data[127:0], ready.
- `busy`  out  1  high while a transaction is outstanding (BUSY or RESP).

## Operation
- FSM has three states: IDLE, BUSY and RESP. Reset enters IDLE.
- **IDLE:** if `mem_req.valid` is high, latch addr, data and rw into the request register.
  - Load the latency counter with `READ_LAT` or `WRITE_LAT`, selected by rw.
  - Go to BUSY.
- **BUSY:** the counter decrements each cycle. In the cycle where the counter equals 1:
  - Write: the latched data is committed to `array[idx]`.
  - Read: `array[idx]` is captured into the response register.
  - Either way, go to RESP.
- **RESP:** `mem_data.ready` is high for exactly this one cycle. Then go to IDLE.
- Line index: `idx = addr[4 +: log2(LINES)]`.
  - `addr[3:0]` (byte offset within the line) is ignored.
  - Address bits above the index are ignored, so the address space aliases modulo `LINES`.
- Response data:
  - Read: the stored line.
  - Write: echoes the written line.
  - `mem_data.data` holds its value until the next response is loaded.
- The request is sampled only in IDLE. Changes to `mem_req` during BUSY or RESP are ignored.
  - If valid drops mid-transaction, the transaction still completes.
- `mem_req.valid` is ignored in RESP. The requester drops or replaces valid in the cycle after it sees ready.
- Back-to-back operation: a request present in the cycle after RESP is accepted immediately.
  - A read following a write to the same idx returns the new data.
- Array contents are not cleared by reset; contents are undefined until written.
  - The bench must write a line before reading it.
- Reset during BUSY aborts the transaction: no array write, and ready never pulses.
- `busy` equals (state != IDLE).

## Timing
- Reset values: `mem_data.ready = 0`, `mem_data.data = 0`, `busy = 0`, state IDLE, counter 0.
- Accept in cycle c gives:
  - BUSY in cycles c+1 to c+LAT.
  - `ready = 1` in cycle c+LAT+1.
  - `ready = 0` and state IDLE in cycle c+LAT+2.
- Round-trip cycle counts, from accept to ready:
  - Read: `READ_LAT + 1` cycles (5 at defaults).
  - Write: `WRITE_LAT + 1` cycles (3 at defaults).
- Maximum throughput is one transaction per LAT+2 cycles.
- All outputs are registered; there is no combinational path from `mem_req` to `mem_data` or `busy`.
- Array write and read-capture occur on the same clock edge, the last BUSY edge. Only one of the two happens per transaction.

## Structure
- Add to the shared `cache_def` package:
  - `LINE_OFF_BITS = 4`.
  - State enum `mem_state_type {IDLE, BUSY, RESP}`.
- `mem_req_type`, `mem_data_type` and `cache_data_type` are reused unchanged.
- Counter width is `$clog2(max(READ_LAT, WRITE_LAT) + 1)`.
- One sub-module, `mem_line_array`:
  - Single-port synchronous RAM, `LINES` × 128.
  - Signals: we, idx, wdata, and registered rdata.
  - It isolates the storage so a vendor macro can be substituted.

## Test plan
- **Reset:** hold `rst_n = 0` for 3 cycles with `valid = 1`, rw = 1 → ready, busy and data stay 0, and no write occurs (a subsequent read of that idx does not return the write data).
- **Write then read:**
  - Write addr 0x0000_0040 (idx 4) with data 0xDEADBEEF_00112233_44556677_8899AABB → ready in cycle c+3.
  - Back-to-back read of 0x0000_0040 → ready at accept+5 with the same 128-bit value.
- **Aliasing/offset:**
  - Write 0x0000_0010 with data A, and write 0x0001_0010 with data B (LINES = 4096).
  - Read 0x0000_001C → returns B.
- **Latency parameterisation:** with READ_LAT = 1 and WRITE_LAT = 7:
  - Read ready at accept+2.
  - Write ready at accept+8.
  - busy is high across exactly LAT+1 cycles.
- **Stimulus change mid-transaction:**
  - Change addr, data and rw, and drop valid, during BUSY → the originally latched operation completes with unchanged latency.
  - A new request is accepted only in the cycle after RESP.
- **Reset mid-BUSY:**
  - Start a write of 0xFFFF…FFFF to idx 9, with idx 9 previously holding 0x1.
  - Pulse `rst_n` low for one cycle during BUSY → no ready pulse, busy = 0 after reset, and a later read of idx 9 returns 0x1.
